// File: rtl/seq_sum_n.sv
// seq_sum_n: sequential N-operand adder.
// A high r_enable captures the operand bus and starts a run; LANES operands are
// folded into the accumulator per clock, and the final sum is presented with a
// sticky overflow flag and an optional saturating mode.
module seq_sum_n #(
   parameter int N_IN  = 7,
   parameter int IN_W  = 10,
   parameter int OUT_W = 13,
   parameter int LANES = 1
) (
   input  logic                   clk,
   input  logic                   r_enable,
   input  logic                   sat_mode,
   input  logic [N_IN*IN_W-1:0]   operands,
   output logic                   busy,
   output logic                   w_enable,
   output logic                   overflow,
   output logic [OUT_W-1:0]       result
);

   // Partial sums carry enough headroom for acc plus LANES full-scale operands.
   localparam int SUM_W  = OUT_W + $clog2(LANES + 1);
   // The index must reach N_IN - 1 + LANES after the last group without wrapping.
   localparam int IDX_W  = $clog2(N_IN + LANES + 1);
   localparam int BUS_W  = N_IN * IN_W;
   localparam int BASE_W = (BUS_W > 1) ? $clog2(BUS_W) : 1;
   localparam logic [OUT_W-1:0] ACC_MAX = '1;
   localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(ACC_MAX);

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      DONE
   } state_t;

   state_t                 state;
   logic [BUS_W-1:0]       opsQ;
   logic                   satQ;
   logic [OUT_W-1:0]       acc;
   logic [IDX_W-1:0]       idx;

   logic [SUM_W-1:0]       laneSum;
   logic [SUM_W-1:0]       nextSum;
   logic [OUT_W-1:0]       nextAcc;
   logic                   ovfNow;
   logic                   lastGroup;
   int                     pos;

   // Sum the current group of operands in ascending index order; slots past
   // the last operand contribute nothing.
   always_comb begin
      laneSum = '0;
      pos     = 0;
      for (int k = 0; k < LANES; k++) begin
         pos = int'(idx) + k;
         if (pos < N_IN) begin
            laneSum = laneSum + SUM_W'(opsQ[BASE_W'(pos * IN_W) +: IN_W]);
         end
      end
   end

   // Once a saturating run has overflowed, the accumulator stays pinned at
   // full scale for the remainder of the run, even if later operands are zero.
   assign nextSum   = SUM_W'(acc) + laneSum;
   assign ovfNow    = (nextSum > SUM_MAX);
   assign nextAcc   = (satQ && (ovfNow || overflow)) ? ACC_MAX : nextSum[OUT_W-1:0];
   assign lastGroup = ((int'(idx) + LANES) >= N_IN);

   // Control FSM and datapath registers; r_enable reloads from any state and
   // always wins over a completing run.
   always_ff @(posedge clk) begin
      if (r_enable) begin
         opsQ     <= operands;
         satQ     <= sat_mode;
         acc      <= '0;
         idx      <= '0;
         state    <= RUN;
         busy     <= 1'b1;
         w_enable <= 1'b0;
         overflow <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (ovfNow) begin
                  overflow <= 1'b1;
               end
               acc <= nextAcc;
               idx <= idx + IDX_W'(LANES);
               if (lastGroup) begin
                  result   <= nextAcc;
                  w_enable <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_sum_n.sv
// tb_seq_sum_n: directed bench for seq_sum_n covering several parameter sets
// that share one r_enable/sat_mode stimulus stream.
module tb_seq_sum_n;

   logic        clk;
   logic        rEnable;
   logic        satMode;
   logic [69:0] ops7;
   logic [9:0]  op1;

   logic        busyV [5];
   logic        wV    [5];
   logic        ovfV  [5];
   logic [12:0] resDef;
   logic [12:0] resL3;
   logic [12:0] resL7;
   logic [9:0]  resW10;
   logic [12:0] resN1;

   int total = 0;
   int bad   = 0;

   // Parameter sets: 0 defaults, 1 LANES=3, 2 LANES=7, 3 OUT_W=10, 4 N_IN=1.
   int pN [5] = '{7, 7, 7, 7, 1};
   int pL [5] = '{1, 3, 7, 1, 1};
   int pW [5] = '{13, 13, 13, 10, 13};

   int mT       [5];
   bit mStarted [5];
   bit mSat     [5];
   int mOp      [5][7];

   seq_sum_n #(.N_IN(7), .IN_W(10), .OUT_W(13), .LANES(1)) dutDef (
      .clk(clk), .r_enable(rEnable), .sat_mode(satMode), .operands(ops7),
      .busy(busyV[0]), .w_enable(wV[0]), .overflow(ovfV[0]), .result(resDef));
   seq_sum_n #(.N_IN(7), .IN_W(10), .OUT_W(13), .LANES(3)) dutL3 (
      .clk(clk), .r_enable(rEnable), .sat_mode(satMode), .operands(ops7),
      .busy(busyV[1]), .w_enable(wV[1]), .overflow(ovfV[1]), .result(resL3));
   seq_sum_n #(.N_IN(7), .IN_W(10), .OUT_W(13), .LANES(7)) dutL7 (
      .clk(clk), .r_enable(rEnable), .sat_mode(satMode), .operands(ops7),
      .busy(busyV[2]), .w_enable(wV[2]), .overflow(ovfV[2]), .result(resL7));
   seq_sum_n #(.N_IN(7), .IN_W(10), .OUT_W(10), .LANES(1)) dutW10 (
      .clk(clk), .r_enable(rEnable), .sat_mode(satMode), .operands(ops7),
      .busy(busyV[3]), .w_enable(wV[3]), .overflow(ovfV[3]), .result(resW10));
   seq_sum_n #(.N_IN(1), .IN_W(10), .OUT_W(13), .LANES(1)) dutN1 (
      .clk(clk), .r_enable(rEnable), .sat_mode(satMode), .operands(op1),
      .busy(busyV[4]), .w_enable(wV[4]), .overflow(ovfV[4]), .result(resN1));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int getRes(input int d);
      case (d)
         0:       return int'(resDef);
         1:       return int'(resL3);
         2:       return int'(resL7);
         3:       return int'(resW10);
         default: return int'(resN1);
      endcase
   endfunction

   function automatic int kOf(input int d);
      return (pN[d] + pL[d] - 1) / pL[d];
   endfunction

   function automatic logic [69:0] pack7(input int a0, a1, a2, a3, a4, a5, a6);
      return {10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference model: remembers captured operands and counts edges since the
   // last load; outputs are derived from plain sums over those operands.
   always @(posedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (rEnable) begin
            mStarted[d] = 1'b1;
            mT[d]       = 0;
            mSat[d]     = satMode;
            for (int i = 0; i < 7; i++) begin
               if (d == 4) mOp[d][i] = (i == 0) ? int'(op1) : 0;
               else        mOp[d][i] = int'(ops7[7'(i * 10) +: 10]);
            end
         end else if (mStarted[d] && mT[d] < kOf(d)) begin
            mT[d] = mT[d] + 1;
         end
      end
   end

   // Every falling edge, compare all instances against the model.
   always @(negedge clk) begin
      int maxV, tot, pre, used, eB, eW, eO, eR;
      for (int d = 0; d < 5; d++) begin
         if (mStarted[d]) begin
            maxV = (1 << pW[d]) - 1;
            tot  = 0;
            for (int i = 0; i < pN[d]; i++) tot += mOp[d][i];
            if (mT[d] < kOf(d)) begin
               used = (mT[d] * pL[d] < pN[d]) ? mT[d] * pL[d] : pN[d];
               pre  = 0;
               for (int i = 0; i < used; i++) pre += mOp[d][i];
               eB = 1; eW = 0; eR = 0;
               eO = (pre > maxV) ? 1 : 0;
            end else begin
               eB = 0; eW = 1;
               eO = (tot > maxV) ? 1 : 0;
               if (mSat[d]) eR = (tot > maxV) ? maxV : tot;
               else         eR = tot % (maxV + 1);
            end
            checkOutput($sformatf("m%0d_busy_t%0d", d, mT[d]), int'(busyV[d]), eB);
            checkOutput($sformatf("m%0d_wen_t%0d", d, mT[d]), int'(wV[d]), eW);
            checkOutput($sformatf("m%0d_ovf_t%0d", d, mT[d]), int'(ovfV[d]), eO);
            checkOutput($sformatf("m%0d_res_t%0d", d, mT[d]), getRes(d), eR);
         end
      end
   end

   task automatic waitEdges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a falling edge: loads for 'hold' rising edges, then releases
   // r_enable and scrambles the bus to show it is ignored during the run.
   task automatic applyStimulus(input logic [69:0] ops, input logic [9:0] one,
                                input logic sat, input int hold);
      ops7    = ops;
      op1     = one;
      satMode = sat;
      rEnable = 1'b1;
      repeat (hold) @(negedge clk);
      rEnable = 1'b0;
      ops7    = ~ops;
      op1     = ~one;
      satMode = ~sat;
   endtask

   initial begin
      rEnable = 1'b0;
      satMode = 1'b0;
      ops7    = '0;
      op1     = '0;

      // Defaults run, plus LANES=3/7 and N_IN=1 side by side.
      applyStimulus(pack7(1, 2, 3, 4, 5, 6, 7), 10'd513, 1'b0, 1);
      checkOutput("def_busy_e0", int'(busyV[0]), 1);
      checkOutput("def_wen_e0", int'(wV[0]), 0);
      checkOutput("def_res_e0", int'(resDef), 0);
      waitEdges(1);
      checkOutput("n1_res_k1", int'(resN1), 513);
      checkOutput("l7_res_k1", int'(resL7), 28);
      checkOutput("l7_wen_k1", int'(wV[2]), 1);
      waitEdges(2);
      checkOutput("l3_res_k3", int'(resL3), 28);
      waitEdges(3);
      checkOutput("def_wen_e6", int'(wV[0]), 0);
      checkOutput("def_busy_e6", int'(busyV[0]), 1);
      waitEdges(1);
      checkOutput("def_res_e7", int'(resDef), 28);
      checkOutput("def_wen_e7", int'(wV[0]), 1);
      checkOutput("def_ovf_e7", int'(ovfV[0]), 0);
      waitEdges(20);
      checkOutput("def_res_hold", int'(resDef), 28);

      // Full-scale operands, wrap then saturate.
      applyStimulus(pack7(1023, 1023, 1023, 1023, 1023, 1023, 1023), 10'd1023, 1'b0, 1);
      waitEdges(7);
      checkOutput("w10_wrap_res", int'(resW10), 1017);
      checkOutput("w10_wrap_ovf", int'(ovfV[3]), 1);
      checkOutput("def_full_res", int'(resDef), 7161);
      checkOutput("def_full_ovf", int'(ovfV[0]), 0);
      applyStimulus(pack7(1023, 1023, 1023, 1023, 1023, 1023, 1023), 10'd1023, 1'b1, 1);
      waitEdges(7);
      checkOutput("w10_sat_res", int'(resW10), 1023);
      checkOutput("w10_sat_ovf", int'(ovfV[3]), 1);

      // Mixed values, wrap then saturate.
      applyStimulus(pack7(1000, 900, 800, 700, 600, 500, 400), 10'd0, 1'b0, 1);
      waitEdges(7);
      checkOutput("w10_mix_wrap", int'(resW10), 804);
      applyStimulus(pack7(1000, 900, 800, 700, 600, 500, 400), 10'd0, 1'b1, 1);
      waitEdges(7);

      // Restart mid-run at E0+3.
      applyStimulus(pack7(1, 2, 3, 4, 5, 6, 7), 10'd5, 1'b0, 1);
      waitEdges(2);
      applyStimulus(pack7(2, 2, 2, 2, 2, 2, 2), 10'd5, 1'b0, 1);
      waitEdges(6);
      checkOutput("restart_wen_e6", int'(wV[0]), 0);
      waitEdges(1);
      checkOutput("restart_res", int'(resDef), 14);

      // r_enable held for four edges on the single-operand instance.
      op1     = 10'd513;
      satMode = 1'b0;
      rEnable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("hold_busy_%0d", i), int'(busyV[4]), 1);
         checkOutput($sformatf("hold_wen_%0d", i), int'(wV[4]), 0);
         checkOutput($sformatf("hold_res_%0d", i), int'(resN1), 0);
      end
      rEnable = 1'b0;
      waitEdges(1);
      checkOutput("hold_res_after", int'(resN1), 513);

      // Reload lands on the final edge of a defaults run.
      applyStimulus(pack7(1, 2, 3, 4, 5, 6, 7), 10'd3, 1'b0, 1);
      waitEdges(6);
      applyStimulus(pack7(10, 20, 30, 40, 50, 60, 70), 10'd3, 1'b0, 1);
      checkOutput("collide_wen_e0", int'(wV[0]), 0);
      waitEdges(6);
      checkOutput("collide_wen_e6", int'(wV[0]), 0);
      waitEdges(1);
      checkOutput("collide_res", int'(resDef), 280);
      checkOutput("collide_wen_e7", int'(wV[0]), 1);

      waitEdges(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_sum_n.md
# seq_sum_n

Parametrised sequential N-operand adder. It captures N_IN operands on the load/reset strobe and accumulates them through LANES shared adders, one group per cycle. It then presents the sum with a sticky overflow flag and an optional saturating mode. It is the generalised successor to the fixed 7-input, single-adder summation unit in the generated-datapath library, and uses the same load/start protocol (`r_enable` in, `w_enable` out).

## Interface
- N_IN, default 7: number of operands; must be ≥1.
- IN_W, default 10: operand width, unsigned.
- OUT_W, default 13: accumulator and result width; must be ≥ IN_W.
- LANES, default 1: operands consumed per cycle; 1 ≤ LANES ≤ N_IN.

Ports:
- clk  in  1: single clock; all state changes on its rising edge.
- r_enable  in  1: reset, synchronous and active-high. It also loads the operands and starts a run.
- sat_mode  in  1: 0 = wrap modulo 2^OUT_W; 1 = clamp to 2^OUT_W−1. Sampled only while r_enable=1.
- operands  in  N_IN*IN_W: flat operand bus; operand i occupies bits [i*IN_W +: IN_W]. Sampled only while r_enable=1.
- busy  out  1: high while accumulation is in progress.
- w_enable  out  1: result valid; level signal, held until the next r_enable.
- overflow  out  1: sticky flag; set if any partial sum exceeded 2^OUT_W−1. Set in either mode.
- result  out  OUT_W: final sum.

## Operation
- States: LOAD, RUN, DONE. Before the first r_enable, all state and outputs are undefined.
- Any edge with r_enable=1 (reset/load), from any state, including mid-RUN or DONE:
  - capture operands and sat_mode
  - acc←0, idx←0, state←RUN
  - busy←1, w_enable←0, overflow←0, result←0
  - An in-flight run is discarded with no output.
- r_enable held high for several cycles reloads on every edge. RUN starts at the first edge with r_enable=0.
- RUN edge (r_enable=0):
  - next = acc + Σ operand[idx+k] for k=0..LANES−1; indices ≥ N_IN contribute 0.
  - Compute `next` at OUT_W + clog2(LANES+1) bits.
  - If next > 2^OUT_W−1, set overflow.
  - Update acc: in wrap mode, acc←next mod 2^OUT_W. In sat mode, acc←2^OUT_W−1, and acc stays clamped for the rest of the run.
  - idx ← idx + LANES.
- Final RUN edge (idx+LANES ≥ N_IN):
  - result←the new acc value, same edge.
  - w_enable←1, busy←0, state←DONE.
- DONE: result, overflow and w_enable hold; r_enable is ignored until reasserted. There is no self-restart.
- Reduction order is by ascending operand index. The wrapped result equals the true sum mod 2^OUT_W regardless of LANES.

## Timing
- Let E0 be the last edge with r_enable=1, and K = ceil(N_IN/LANES).
- busy=1 from E0 through edge E0+K−1.
- result, overflow and w_enable=1 are visible immediately after edge E0+K.
- Latency from E0 is K cycles. Defaults give K=7; LANES=N_IN gives K=1.
- w_enable never pulses. It is a level and falls only at an r_enable edge.
- If r_enable is asserted on the same edge as the final RUN edge, r_enable wins: w_enable stays 0 and a new run starts.
- Operand bus changes while r_enable=0 have no effect.
- The adder chain per cycle is LANES deep. Timing closure at large LANES is the integrator's responsibility.

## Test plan
- Defaults, operands 1,2,3,4,5,6,7, sat_mode=0:
  - w_enable rises exactly 7 edges after E0 with result=28, overflow=0.
  - busy high for edges E0..E0+6.
  - Outputs hold for 20 more cycles.
- LANES=3, same operands: result=28 after 3 edges; LANES=7: after 1 edge. Values match the LANES=1 result.
- OUT_W=10, all operands 1023:
  - sat_mode=0 → result=1017, overflow=1.
  - sat_mode=1 → result=1023, overflow=1.
  - OUT_W=13 → result=7161, overflow=0.
- Restart mid-run: operands 1..7, then r_enable re-pulsed at E0+3 with all operands 2. w_enable stays 0 until 7 edges after the new E0, then result=14.
- N_IN=1, LANES=1, operand 513: result=513 one edge after E0. r_enable held high for 4 cycles keeps busy=1, w_enable=0, result=0 throughout.
- Final-edge collision: r_enable asserted on edge E0+7 of a defaults run. w_enable never rises for the old run, and the new run completes 7 edges later.
